// File: rtl/l1_cache_if.sv
// CPU-side and next-level-memory-side signals of the L1 cache.
// The cache connects through the slave modport; the CPU/memory side uses master.
interface l1_cache_if #(
  parameter int LINE_W = 256
);
  logic              mem_read;
  logic              mem_write;
  logic [3:0]        mem_byte_enable;
  logic [31:0]       mem_address;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic              hit;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, hit,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, hit,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache.
// Hits are answered combinationally in the request cycle; misses write back a
// dirty victim line, fill the new line, then complete as an ordinary hit.
module l1_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3
) (
  input  logic        clk,
  input  logic        reset,
  l1_cache_if.slave   bus
);
  localparam int TAG_W  = 32 - s_offset - s_index;
  localparam int SETS   = 1 << s_index;
  localparam int LINE_W = 8 << s_offset;
  localparam int WORD_W = s_offset - 2;

  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_e;

  state_e              state_q, state_d;
  logic                missed_q, missed_d;
  logic                pmem_read_q, pmem_read_d;
  logic                pmem_write_q, pmem_write_d;
  logic                valid_q [SETS];
  logic                valid_d [SETS];
  logic                dirty_q [SETS];
  logic                dirty_d [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS];
  logic [TAG_W-1:0]    tag_d   [SETS];
  logic [LINE_W-1:0]   data_q  [SETS];
  logic [LINE_W-1:0]   data_d  [SETS];

  logic [TAG_W-1:0]    req_tag;
  logic [s_index-1:0]  idx;
  logic [WORD_W-1:0]   word;
  logic                req;
  logic                tag_hit;
  logic                resp;
  logic                unused_addr_lsb;

  assign req_tag         = bus.mem_address[31 -: TAG_W];
  assign idx             = bus.mem_address[s_offset +: s_index];
  assign word            = bus.mem_address[2 +: WORD_W];
  assign unused_addr_lsb = ^bus.mem_address[1:0];
  assign req             = bus.mem_read | bus.mem_write;
  assign tag_hit         = valid_q[idx] && (tag_q[idx] == req_tag);
  assign resp            = (state_q == CHECK) && req && tag_hit;

  // Miss sequencing: CHECK -> [WRITEBACK] -> FILL -> CHECK; pmem strobes registered from next state
  always_comb begin
    state_d  = state_q;
    missed_d = missed_q;
    case (state_q)
      CHECK: begin
        if (req && !tag_hit) begin
          missed_d = 1'b1;
          state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
        end else if (resp) begin
          missed_d = 1'b0;
        end
      end
      WRITEBACK: if (bus.pmem_resp) state_d = FILL;
      FILL:      if (bus.pmem_resp) state_d = CHECK;
      default:   state_d = CHECK;
    endcase
    pmem_read_d  = (state_d == FILL);
    pmem_write_d = (state_d == WRITEBACK);
  end

  // Line storage updates: byte-lane merge on a write hit, whole-line load on fill completion
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (resp && bus.mem_write) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_byte_enable[b]) begin
          data_d[idx][int'(word)*32 + b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
        end
      end
      dirty_d[idx] = 1'b1;
    end
    if ((state_q == FILL) && bus.pmem_resp) begin
      data_d[idx]  = bus.pmem_rdata;
      tag_d[idx]   = req_tag;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
  end

  // Control state; reset invalidates every line and abandons any miss in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CHECK;
      missed_q     <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      valid_q      <= '{default: 1'b0};
      dirty_q      <= '{default: 1'b0};
    end else begin
      state_q      <= state_d;
      missed_q     <= missed_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; stale contents are masked by valid
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.mem_resp     = resp;
  assign bus.hit          = resp & ~missed_q;
  assign bus.mem_rdata    = data_q[idx][int'(word)*32 +: 32];
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = (state_q == WRITEBACK) ? {tag_q[idx], idx, {s_offset{1'b0}}}
                                                   : {req_tag, idx, {s_offset{1'b0}}};
  assign bus.pmem_wdata   = data_q[idx];
endmodule

// File: tb/tb_l1_cache.sv
// Testbench for l1_cache: directed scenarios followed by randomized accesses,
// checked against a memory-level reference model (architectural memory plus a
// tag/valid/dirty directory) with a scripted next-level memory.
module tb_l1_cache;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_cache_if bus ();
  l1_cache dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  logic [31:0]  arch_mem [bit [31:0]];   // CPU-visible words written but not yet in store
  logic [255:0] pstore   [bit [31:0]];   // next-level memory lines
  bit           mv [8];
  bit           md [8];
  logic [23:0]  mt [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ (a << 7);
  endfunction

  function automatic logic [255:0] store_line(input logic [31:0] la);
    logic [255:0] l;
    if (pstore.exists(la)) return pstore[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w*4));
    return l;
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [255:0] l;
    if (arch_mem.exists(a)) return arch_mem[a];
    l = store_line({a[31:5], 5'b0});
    return l[int'(a[4:2])*32 +: 32];
  endfunction

  function automatic logic [255:0] arch_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_word(la + 32'(w*4));
    return l;
  endfunction

  // One CPU access from request to completion; starts and ends at a falling edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int wlat, input int flat);
    logic [2:0]  idx;
    logic [23:0] tg;
    logic [31:0] wa, la, vla, merged;
    bit          is_hit, do_wb;
    int          nw, nf, rc;
    idx    = addr[7:5];
    tg     = addr[31:8];
    wa     = {addr[31:2], 2'b00};
    la     = {addr[31:5], 5'b0};
    is_hit = mv[idx] && (mt[idx] == tg);
    do_wb  = !is_hit && mv[idx] && md[idx];
    vla    = {mt[idx], idx, 5'b0};
    nw     = do_wb ? wlat : 0;
    nf     = is_hit ? 0 : flat;
    rc     = is_hit ? 0 : nw + nf + 1;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    for (int c = 0; c <= rc; c++) begin
      bit e_pw, e_pr, e_rs;
      #1;
      e_rs = (c == rc);
      e_pw = (c >= 1) && (c <= nw);
      e_pr = !is_hit && (c > nw) && (c <= nw + nf);
      chk("mem_resp", bus.mem_resp, e_rs);
      chk("pmem_write", bus.pmem_write, e_pw);
      chk("pmem_read", bus.pmem_read, e_pr);
      if (e_pw) begin
        chk("wb_addr", bus.pmem_address, vla);
        chk("wb_data", bus.pmem_wdata, arch_line(vla));
        if (c == nw) begin
          bus.pmem_resp = 1'b1;
          pstore[vla] = arch_line(vla);
        end
      end
      if (e_pr) begin
        chk("fill_addr", bus.pmem_address, la);
        bus.pmem_rdata = store_line(la);
        if (c == nw + nf) bus.pmem_resp = 1'b1;
      end
      if (e_rs) begin
        chk("hit", bus.hit, is_hit);
        if (!wr) chk("rdata", bus.mem_rdata, arch_word(wa));
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
    end
    if (wr) begin
      merged = arch_word(wa);
      for (int b = 0; b < 4; b++) if (be[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
      arch_mem[wa] = merged;
    end
    md[idx] = (is_hit ? md[idx] : 1'b0) | wr;
    mv[idx] = 1'b1;
    mt[idx] = tg;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    chk("idle_resp", bus.mem_resp, 1'b0);
    chk("idle_hit", bus.hit, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] t;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_byte_enable = 0;
    bus.mem_address = 0; bus.mem_wdata = 0; bus.pmem_rdata = '0; bus.pmem_resp = 0;
    for (int s = 0; s < 8; s++) begin mv[s] = 0; md[s] = 0; mt[s] = '0; end
    t = store_line(32'h40);
    t[95:64] = 32'hDEADBEEF;
    pstore[32'h40] = t;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp", bus.mem_resp, 1'b0);
    chk("rst_hit", bus.hit, 1'b0);
    chk("rst_pread", bus.pmem_read, 1'b0);
    chk("rst_pwrite", bus.pmem_write, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Cold read miss, then repeat hit, write merge, read-back
    access(1, 0, 32'h48, 4'h0, 32'h0, 1, 3);
    chk("first_word", arch_word(32'h48), 32'hDEADBEEF);
    access(1, 0, 32'h48, 4'h0, 32'h0, 1, 1);
    access(0, 1, 32'h48, 4'b0011, 32'h1234_5678, 1, 1);
    access(1, 0, 32'h48, 4'h0, 32'h0, 1, 1);
    chk("merged_word", arch_word(32'h48), 32'hDEAD5678);
    // Conflict miss with a dirty victim: writeback then fill
    access(1, 0, 32'h148, 4'h0, 32'h0, 2, 2);
    chk("wb_stored", pstore[32'h40][95:64], 32'hDEAD5678);

    // Reset during FILL, with a pmem_resp in the reset cycle
    bus.mem_read = 1'b1; bus.mem_address = 32'h260;
    #1;
    chk("rf_c0_resp", bus.mem_resp, 1'b0);
    @(negedge clk);
    #1;
    chk("rf_fill", bus.pmem_read, 1'b1);
    chk("rf_addr", bus.pmem_address, 32'h260);
    @(negedge clk);
    reset = 1'b1; bus.mem_read = 1'b0;
    bus.pmem_rdata = store_line(32'h260); bus.pmem_resp = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.pmem_resp = 1'b0;
    #1;
    chk("rf_pread_drop", bus.pmem_read, 1'b0);
    chk("rf_pwrite", bus.pmem_write, 1'b0);
    chk("rf_resp", bus.mem_resp, 1'b0);
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin mv[s] = 0; md[s] = 0; end
    arch_mem.delete();
    access(1, 0, 32'h260, 4'h0, 32'h0, 1, 2);

    // Read and write together on a hit behaves as a write
    access(1, 0, 32'h14C, 4'h0, 32'h0, 1, 2);
    access(1, 1, 32'h14C, 4'b1100, 32'hA1B2_C3D4, 1, 1);
    access(1, 0, 32'h14C, 4'h0, 32'h0, 1, 1);

    // Randomized traffic over a few conflicting tags
    for (int i = 0; i < 250; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = {24'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      access(op != 1, op != 0, a, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(1, 3), $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
